irq_ctrl: RTL

//  Parametrised vectored interrupt controller for the pipelined processor; generalises the single 'int' pin.

---
 rtl/irq_ctrl_pkg.sv | 28 ++
 rtl/irq_ctrl_prio_enc.sv | 31 +++
 rtl/irq_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : irq_ctrl_pkg
// Purpose : Shared definitions for the vectored interrupt controller:
//           processor address width, vector-table base, reset-vector
//           address, handshake FSM encodings and the irq_id width helper.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package irq_ctrl_pkg;

    localparam int         c_ADDR_W    = 8;
    localparam logic [7:0] c_VEC_BASE  = 8'h01;
    localparam logic [7:0] c_RESET_VEC = 8'h00;

    // Handshake FSM encodings
    localparam int               c_ST_W    = 2;
    localparam logic [c_ST_W-1:0] c_ST_IDLE = 2'd0;
    localparam logic [c_ST_W-1:0] c_ST_REQ  = 2'd1;
    localparam logic [c_ST_W-1:0] c_ST_VEC  = 2'd2;

    // Index width for n lines; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_ctrl_prio_enc.sv
`default_nettype none
// ============================================================================
// Module  : irq_prio_enc
// Purpose : Lowest-index-first priority encoder.
// Ports   : i_req   [N-1:0]    request vector
//           o_valid             at least one request bit set
//           o_idx   [ID_W-1:0]  index of the lowest set bit (0 when none)
// Revision: 1.0 - initial release
// ============================================================================
module irq_prio_enc #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    i_req,
    output logic            o_valid,
    output logic [ID_W-1:0] o_idx
);

    // Scanning downwards lets the lowest set index overwrite higher ones.
    always_comb begin
        o_valid = |i_req;
        o_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx = ID_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : irq_ctrl
// Purpose : Vectored, nestable interrupt controller. Synchronises, latches,
//           masks and prioritises N_IRQ lines, requests the pipeline, then
//           supplies the vector-table address of the granted line.
// Ports   : clk, rst (sync, active-low)
//           irq[N_IRQ]         external lines (asynchronous)
//           mask_we/mask_wdata mask register write port (1 = masked)
//           int_ack            control unit accepted the request
//           rti_done           RTI retired; closes current service level
//           int_req/irq_id     request and granted line
//           vec_valid/vec_addr one-cycle vector-address strobe
//           pending/in_service state visibility
// Revision: 1.0 - initial release
// ============================================================================
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int                N_IRQ      = 4,
    parameter int                ADDR_W     = c_ADDR_W,
    parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(c_VEC_BASE),
    parameter int                VEC_STRIDE = 1,
    parameter logic [N_IRQ-1:0]  EDGE_MASK  = '1,
    parameter logic [N_IRQ-1:0]  MASK_RST   = '0,
    localparam int               ID_W       = id_width(N_IRQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_IRQ-1:0]  irq,
    input  logic              mask_we,
    input  logic [N_IRQ-1:0]  mask_wdata,
    input  logic              int_ack,
    input  logic              rti_done,
    output logic              int_req,
    output logic [ID_W-1:0]   irq_id,
    output logic              vec_valid,
    output logic [ADDR_W-1:0] vec_addr,
    output logic [N_IRQ-1:0]  pending,
    output logic [N_IRQ-1:0]  in_service
);

    logic [N_IRQ-1:0]  r_irq_s;
    logic [N_IRQ-1:0]  r_irq_prev;
    logic [N_IRQ-1:0]  r_pending;
    logic [N_IRQ-1:0]  r_in_service;
    logic [N_IRQ-1:0]  r_mask;
    logic [c_ST_W-1:0] r_state;
    logic [c_ST_W-1:0] w_state_next;
    logic [ID_W-1:0]   r_irq_id;
    logic [ADDR_W-1:0] r_vec_addr;

    logic              w_svc_valid;
    logic [ID_W-1:0]   w_svc_idx;
    logic              w_cand_valid;
    logic [ID_W-1:0]   w_cand_idx;
    logic [N_IRQ-1:0]  w_allowed;
    logic [N_IRQ-1:0]  w_cand_vec;
    logic [N_IRQ-1:0]  w_edge;
    logic [N_IRQ-1:0]  w_ack_onehot;
    logic [N_IRQ-1:0]  w_rti_onehot;
    logic [N_IRQ-1:0]  w_pending_next;
    logic [N_IRQ-1:0]  w_in_service_next;
    logic              w_ack;
    logic              w_grant;
    logic [ADDR_W-1:0] w_vec_calc;

    // Current service level: the highest-priority line being serviced.
    irq_prio_enc #(.N(N_IRQ), .ID_W(ID_W)) u_svc_enc (
        .i_req   (r_in_service),
        .o_valid (w_svc_valid),
        .o_idx   (w_svc_idx)
    );

    // Candidate: highest-priority unmasked pending line above that level.
    irq_prio_enc #(.N(N_IRQ), .ID_W(ID_W)) u_cand_enc (
        .i_req   (w_cand_vec),
        .o_valid (w_cand_valid),
        .o_idx   (w_cand_idx)
    );

    assign w_edge     = r_irq_s & ~r_irq_prev;
    assign w_cand_vec = r_pending & ~r_mask & w_allowed;
    assign w_ack      = (r_state == c_ST_REQ) && int_ack;
    assign w_grant    = (r_state == c_ST_IDLE) && w_cand_valid;

    assign w_ack_onehot = w_ack ? (N_IRQ'(1) << r_irq_id) : '0;
    // RTI closes the level seen before this cycle's ack; the ack bit is
    // always of higher priority, so the two never collide.
    assign w_rti_onehot = (rti_done && w_svc_valid) ? (N_IRQ'(1) << w_svc_idx) : '0;
    assign w_in_service_next = (r_in_service & ~w_rti_onehot) | w_ack_onehot;

    assign w_vec_calc = VEC_BASE + ADDR_W'(ADDR_W'(r_irq_id) * ADDR_W'(VEC_STRIDE));

    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_line
        assign w_allowed[gi] = !w_svc_valid || (ID_W'(gi) < w_svc_idx);
        if (EDGE_MASK[gi]) begin : g_edge
            // A fresh edge on the ack cycle keeps the line pending.
            assign w_pending_next[gi] = w_edge[gi] | (r_pending[gi] & ~w_ack_onehot[gi]);
        end else begin : g_level
            assign w_pending_next[gi] = r_irq_s[gi];
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_irq_s      <= '0;
            r_irq_prev   <= '0;
            r_pending    <= '0;
            r_in_service <= '0;
            r_mask       <= MASK_RST;
            r_irq_id     <= '0;
            r_vec_addr   <= '0;
        end else begin
            r_irq_s      <= irq;
            r_irq_prev   <= r_irq_s;
            r_pending    <= w_pending_next;
            r_in_service <= w_in_service_next;
            if (mask_we) begin
                r_mask <= mask_wdata;
            end
            // irq_id is frozen for the whole REQ phase.
            if (w_grant) begin
                r_irq_id <= w_cand_idx;
            end
            if (w_ack) begin
                r_vec_addr <= w_vec_calc;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state. REQ is never withdrawn, only left on int_ack.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (w_cand_valid) w_state_next = c_ST_REQ;
            c_ST_REQ:  if (int_ack)      w_state_next = c_ST_VEC;
            c_ST_VEC:                    w_state_next = c_ST_IDLE;
            default:                     w_state_next = c_ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        int_req   = 1'b0;
        vec_valid = 1'b0;
        case (r_state)
            c_ST_REQ: int_req   = 1'b1;
            c_ST_VEC: vec_valid = 1'b1;
            default: ;
        endcase
    end

    assign irq_id     = r_irq_id;
    assign vec_addr   = r_vec_addr;
    assign pending    = r_pending;
    assign in_service = r_in_service;

endmodule
`default_nettype wire
